// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default MXU/memory geometry, result-drain FSM states,
// and the helper that locates one element inside the flattened result vector.
package accel_pkg;

  localparam int DEF_NUM_SIZE      = 16;
  localparam int DEF_GRID_SIZE     = 2;
  localparam int DEF_ADDR_W        = 5;
  localparam int DEF_MEM_W         = 8;
  localparam int DEF_SETTLE_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } drain_state_e;

  // Element k (row-major: row*GRID_SIZE+col) starts at bit k*width.
  function automatic int elem_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/drain_convert.sv
// Combinational NUM_SIZE -> MEM_W element conversion, 0 cycles, no flow control.
// Truncates by default; DRAIN_SATURATE_EN clamps signed values to the signed MEM_W range.
module drain_convert #(
  parameter int NUM_SIZE = 16,
  parameter int MEM_W    = 8
) (
  input  logic [NUM_SIZE-1:0] din,
  output logic [MEM_W-1:0]    dout
);

`ifdef DRAIN_SATURATE_EN
  localparam logic signed [NUM_SIZE-1:0] MAX_V = NUM_SIZE'((1 << (MEM_W - 1)) - 1);
  localparam logic signed [NUM_SIZE-1:0] MIN_V = -MAX_V - NUM_SIZE'(1);

  always_comb begin
    if ($signed(din) > MAX_V) begin
      dout = {1'b0, {(MEM_W-1){1'b1}}};
    end else if ($signed(din) < MIN_V) begin
      dout = {1'b1, {(MEM_W-1){1'b0}}};
    end else begin
      dout = din[MEM_W-1:0];
    end
  end
`else
  logic unused_hi;

  assign dout      = din[MEM_W-1:0];
  assign unused_hi = ^din[NUM_SIZE-1:MEM_W];
`endif

endmodule

// File: rtl/mxu_result_drain.sv
// Drains the MXU result tile to memory: settle, snapshot, then one valid/ready write per element.
// Start-to-done is SETTLE_CYCLES+GRID_SIZE^2+2 cycles when unstalled; DRAIN_SATURATE_EN selects clamping.
module mxu_result_drain
  import accel_pkg::*;
#(
  parameter int NUM_SIZE      = DEF_NUM_SIZE,
  parameter int GRID_SIZE     = DEF_GRID_SIZE,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int MEM_W         = DEF_MEM_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDR_W-1:0]                     base_addr,
  input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_in,
  output logic                                  wr_valid,
  output logic [ADDR_W-1:0]                     wr_addr,
  output logic [MEM_W-1:0]                      wr_data,
  input  logic                                  wr_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ELEMS = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  drain_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NUM_SIZE-1:0] snap_q [ELEMS];
  logic [NUM_SIZE-1:0] snap_d [ELEMS];
  logic [MEM_W-1:0]    conv_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      for (int k = 0; k < ELEMS; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      for (int k = 0; k < ELEMS; k++) begin
        snap_q[k] <= snap_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    base_d  = base_q;
    for (int k = 0; k < ELEMS; k++) begin
      snap_d[k] = snap_q[k];
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        // Whole tile is frozen here so late MXU activity cannot corrupt the writes.
        for (int k = 0; k < ELEMS; k++) begin
          snap_d[k] = result_in[elem_lo(k, NUM_SIZE) +: NUM_SIZE];
        end
        idx_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  drain_convert #(
    .NUM_SIZE (NUM_SIZE),
    .MEM_W    (MEM_W)
  ) u_convert (
    .din  (snap_q[idx_q]),
    .dout (conv_dat)
  );

  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    if (state_q == WRITE) begin
      wr_valid = 1'b1;
      wr_addr  = base_q + ADDR_W'(idx_q);
      wr_data  = conv_dat;
    end
  end

endmodule
